// File: rtl/mem_share_grant_sched.sv
// mem_share_grant_sched: serialises flagged requestors onto SHARED_PORT_NUM shared-bank ports, lowest index first
//   sys_clk, rstn          : clock, asynchronous active-low reset
//   rqst_valid_i/ready_o   : batch handshake; ready is high only while idle
//   share_rqstFlag_i       : per-requestor shared-bank request flags
//   rqst_addr_i            : packed column addresses, lane i at [(i+1)*W-1:i*W]
//   grant_valid_o          : grant_mask_o/grant_addr_o are valid this cycle
//   grant_mask_o           : requestors granted this cycle (at most SHARED_PORT_NUM bits set)
//   grant_addr_o           : latched addresses of granted lanes, other lanes zero
//   batch_done_o           : one-cycle pulse when a batch has been fully served
//   round_cnt_o            : grant rounds issued for the current/last batch (saturating)
module mem_share_grant_sched #(
  parameter int SHARED_BANK_NUM    = 5,
  parameter int RQST_ADDR_BITWIDTH = 2,
  parameter int SHARED_PORT_NUM    = 2,
  parameter int ROUND_CNT_BITWIDTH = 3
) (
  input  logic                                        sys_clk,
  input  logic                                        rstn,
  input  logic                                        rqst_valid_i,
  output logic                                        rqst_ready_o,
  input  logic [SHARED_BANK_NUM-1:0]                  share_rqstFlag_i,
  input  logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] rqst_addr_i,
  output logic                                        grant_valid_o,
  output logic [SHARED_BANK_NUM-1:0]                  grant_mask_o,
  output logic [RQST_ADDR_BITWIDTH*SHARED_BANK_NUM-1:0] grant_addr_o,
  output logic                                        batch_done_o,
  output logic [ROUND_CNT_BITWIDTH-1:0]               round_cnt_o
);
  localparam int N = SHARED_BANK_NUM;
  localparam int W = RQST_ADDR_BITWIDTH;
  typedef enum logic {IDLE, SERVE} state_t;
  state_t state, state_nxt;
  logic [N-1:0] pending, sel, rem;
  logic [W*N-1:0] addr_q, addr_sel;
  logic accept;
  int cnt;
  assign rqst_ready_o = state == IDLE;
  assign accept = rqst_valid_i && rqst_ready_o;
  assign rem = pending & ~sel;
  // pick the lowest SHARED_PORT_NUM set bits of pending
  always_comb begin
    sel = '0;
    cnt = 0;
    for (int i = 0; i < N; i++)
      if (pending[i] && cnt < SHARED_PORT_NUM) begin
        sel[i] = 1'b1;
        cnt++;
      end
  end
  for (genvar g = 0; g < N; g++) begin : g_addr
    assign addr_sel[g*W +: W] = sel[g] ? addr_q[g*W +: W] : '0;
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE)
      state_nxt = (accept && |share_rqstFlag_i) ? SERVE : IDLE;
    else
      state_nxt = (rem == '0) ? IDLE : SERVE;
  end
  always_ff @(posedge sys_clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      pending       <= '0;
      addr_q        <= '0;
      grant_valid_o <= 1'b0;
      grant_mask_o  <= '0;
      grant_addr_o  <= '0;
      batch_done_o  <= 1'b0;
      round_cnt_o   <= '0;
    end else if (state == IDLE) begin
      grant_valid_o <= 1'b0;
      grant_mask_o  <= '0;
      grant_addr_o  <= '0;
      // an empty batch completes immediately without any grant round
      batch_done_o  <= accept && share_rqstFlag_i == '0;
      if (accept) begin
        pending     <= share_rqstFlag_i;
        addr_q      <= rqst_addr_i;
        round_cnt_o <= '0;
      end
    end else begin
      grant_valid_o <= 1'b1;
      grant_mask_o  <= sel;
      grant_addr_o  <= addr_sel;
      pending       <= rem;
      round_cnt_o   <= &round_cnt_o ? round_cnt_o : round_cnt_o + 1'b1;
      batch_done_o  <= rem == '0;
    end
  end
endmodule

// File: doc/mem_share_grant_sched.md
Name: mem_share_grant_sched

Overview:
- Sits directly downstream of the group-2 access request flag generator.
- Accepts one batch per handshake: the per-requestor shared-group request flags plus the requestors' column addresses.
- Serialises flagged requestors onto the SHARED_PORT_NUM physical ports of the shared (partially-parallelised) column banks, granting up to SHARED_PORT_NUM requestors per cycle in fixed lowest-index-first priority.
- Signals batch completion so the layer scheduler can issue the next batch.

Parameters:
- SHARED_BANK_NUM, 5, number of requestors in the share group (width of flag vector)
- RQST_ADDR_BITWIDTH, 2, bit width of each requestor's column address
- SHARED_PORT_NUM, 2, maximum grants per cycle (physical ports of the shared banks)
- ROUND_CNT_BITWIDTH, 3, width of grant-round counter; must hold ceil(SHARED_BANK_NUM/SHARED_PORT_NUM)

Ports:
- sys_clk  input  1  system clock, all state on rising edge
- rstn  input  1  asynchronous active-low reset
- rqst_valid_i  input  1  batch valid from upstream
- rqst_ready_o  output  1  block can accept a batch
- share_rqstFlag_i  input  SHARED_BANK_NUM  per-requestor shared-bank request flags
- rqst_addr_i  input  RQST_ADDR_BITWIDTH*SHARED_BANK_NUM  concatenated column addresses; lane i at [(i+1)*W-1:i*W]
- grant_valid_o  output  1  grant_mask_o/grant_addr_o valid this cycle
- grant_mask_o  output  SHARED_BANK_NUM  requestors granted this cycle, popcount <= SHARED_PORT_NUM
- grant_addr_o  output  RQST_ADDR_BITWIDTH*SHARED_BANK_NUM  latched addresses of granted lanes, non-granted lanes zero
- batch_done_o  output  1  one-cycle pulse, batch fully served
- round_cnt_o  output  ROUND_CNT_BITWIDTH  grant rounds issued in current/last batch

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; pending, latched addresses, grant_mask_o, grant_addr_o, round_cnt_o = 0; grant_valid_o, batch_done_o = 0. Any in-flight batch is discarded; no done pulse after reset release.
- rqst_ready_o = (state==IDLE), combinational from state only, never from rqst_valid_i.
- Accept: rqst_valid_i && rqst_ready_o at a rising edge. Latch flags into pending, latch rqst_addr_i, round_cnt_o<=0.
  - Flags nonzero: state<=SERVE.
  - Flags all zero: stay IDLE, batch_done_o<=1 next cycle, no grant, round_cnt_o=0.
- States:
  - IDLE: grant_valid_o<=0, grant_mask_o<=0, grant_addr_o<=0.
  - SERVE: at each edge, sel = lowest SHARED_PORT_NUM set bits of pending.
    - grant_mask_o<=sel; grant_valid_o<=1; grant_addr_o<=latched addr masked by sel.
    - pending<=pending&~sel; round_cnt_o<=round_cnt_o+1, saturating at all-ones.
    - If (pending&~sel)==0: state<=IDLE and batch_done_o<=1, registered together with the last grant.
- batch_done_o is high for exactly one cycle per accepted batch; otherwise 0.
- Latency: first grant visible the cycle after the accept edge; a batch with k flags takes ceil(k/SHARED_PORT_NUM) consecutive grant cycles with no bubbles.
- Back-to-back: ready rises in the cycle the last grant is shown. A new batch can be accepted at the next edge, giving one non-grant cycle between batches.
- Inputs are sampled only at the accept edge; changes to share_rqstFlag_i/rqst_addr_i during SERVE have no effect.
- rqst_valid_i while not ready is ignored; upstream holds it.
- Every pending bit is granted exactly once per batch. No requestor is granted more than once. The popcount of grant_mask_o never exceeds SHARED_PORT_NUM.
- Priority is fixed by index (lane 0 highest); no cross-batch fairness state.

Test Plan:
- Reset then flags=5'b11111, addr lanes {3,2,1,0,3}: grants 00011, 01100, 10000 on three consecutive cycles. grant_addr_o shows only the granted lanes' addresses. batch_done_o coincides with 10000; round_cnt_o=3.
- flags=5'b00000 accepted: no grant_valid_o, batch_done_o one cycle after accept, round_cnt_o=0, ready stays 1.
- flags=5'b10100: single grant 10100 one cycle after accept with done; then immediate second batch 5'b00001 accepted next edge grants 00001 and pulses done.
- Change share_rqstFlag_i/rqst_addr_i every cycle during SERVE of 5'b01111: grants remain 00011 then 01100 using latched addresses.
- Assert rstn=0 between the first and second grant of 5'b11111: outputs zero immediately. After release, ready=1, no done pulse, no further grants.
- Hold rqst_valid_i=1 continuously with random flags over 200 batches: each set bit is granted exactly once per batch, popcount<=2 every cycle, one done per batch.
